di_sel_arbiter: RTL and testbench
=================================

# di_sel_arbiter

Parametrised, registered data-input selector for the microprocessor / DMA data path. It arbitrates among NCH request/data sources (CPU, DMA, protocol peripherals) and captures the winner into a one-word output register. The register is held under a valid/ready handshake toward the consumer. It replaces the fixed three-way combinational DI select with configurable width, channel count and arbitration policy, and keeps a forced-select override for legacy control.

## Interface
- WIDTH, 32, data word width.
- NCH, 4, number of source channels (2..16).
- MODE, 0, arbitration policy: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- IDW, $clog2(NCH), width of channel index (derived, not overridden).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel request; bit i set = data_in slice i valid.
- data_in  in  NCH*WIDTH  flattened source data; channel i at bits [i*WIDTH +: WIDTH].
- force_en  in  1  override: only channel force_sel is eligible.
- force_sel  in  IDW  forced channel index.
- gnt  out  NCH  one-hot, combinational; marks the channel captured at the coming edge.
- D  out  WIDTH  registered output word.
- D_valid  out  1  D holds an unconsumed word.
- D_ready  in  1  consumer accepts D at this edge when D_valid=1.
- gnt_id  out  IDW  registered index of the channel whose word is in D.

## Operation
- Two states, encoded by D_valid:
  - EMPTY: D_valid=0.
  - FULL: D_valid=1.
- load = (any eligible req) && (!D_valid || D_ready).
  - On load: D <= data_in[winner], gnt_id <= winner, D_valid <= 1, gnt[winner] = 1.
- When FULL, D_ready=1 and no eligible req: D_valid <= 0. D and gnt_id keep their last values.
- When FULL and D_ready=0: D, gnt_id and D_valid hold. gnt = 0.
- Eligibility:
  - force_en=0: every channel with req set.
  - force_en=1: only force_sel, and only if req[force_sel]=1.
  - force_sel >= NCH: no channel eligible, gnt = 0.
- Winner selection:
  - MODE 0, or force_en=1: lowest eligible index.
  - MODE 1: first eligible index at or after rr_ptr, wrapping modulo NCH.
    - On a non-forced load, rr_ptr <= winner+1 mod NCH.
    - rr_ptr is unchanged on forced loads and in MODE 0.
- Source contract:
  - A source holds req and its data stable until it sees its gnt bit at a rising edge.
  - It then drops req or presents its next word.
- gnt is never asserted while reset=1.

## Timing
- Reset values: D=0, D_valid=0, gnt_id=0, rr_ptr=0, gnt=0.
- Latency: req sampled at edge n (with load true) -> D/D_valid visible after edge n. One cycle.
- Throughput: one word per cycle while D_ready=1 and requests are present. Back-to-back loads need no bubble.
- Simultaneous accept and load: the old word is consumed and the new word is captured at the same edge. D_valid stays 1.
- Requests change while FULL and stalled: no effect until the load condition is true. Arbitration uses the req value at that edge.
- Reset mid-operation: the held word is discarded. The next cycle is EMPTY with rr_ptr=0. A stalled source whose gnt never came must re-present its data.

## Structure
- Shared package di_pkg holds:
  - policy constants DI_MODE_FIXED=0 and DI_MODE_RR=1;
  - a clog2 helper function.
- Sub-module di_rr_arbiter: combinational, parametrised by NCH.
  - Inputs: eligible vector, rr_ptr, mode.
  - Outputs: one-hot grant and index.
- The top level holds the output register, D_valid, gnt_id, rr_ptr and the load logic.

## Test plan
- Reset and basic load:
  - Stimulus: reset 2 cycles, then req=4'b0010 with data_in ch1=32'hDEADBEEF, D_ready=1.
  - Response: gnt=4'b0010 in that cycle; next cycle D=DEADBEEF, D_valid=1, gnt_id=1.
- Fixed priority:
  - Stimulus: MODE 0, req=4'b1110 held constantly.
  - Response: ch1 wins every cycle; ch2 and ch3 are never granted.
- Round-robin:
  - Stimulus: MODE 1, req=4'b1111 held, D_ready=1.
  - Response: gnt_id sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure:
  - Stimulus: D_valid=1, D_ready=0 for 3 cycles with req=4'b0100.
  - Response: D, gnt_id and D_valid unchanged; gnt=0. Raising D_ready captures ch2 at that same edge.
- Force and reset boundaries:
  - Stimulus: force_en=1, force_sel=3, req=4'b1001.
    - Response: ch3 captured and rr_ptr unchanged.
  - Stimulus: force_sel=3 with NCH=3.
    - Response: no grant.
  - Stimulus: reset asserted while FULL.
    - Response: D_valid=0 and D=0 next cycle.

Source files
------------

// File: rtl/di_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : di_pkg
//  Purpose  : Shared definitions for the DI selector / arbiter slice.
//             Arbitration policy constants, state encoding and a
//             clog2 helper for deriving index widths.
//  Revision : 1.0 - initial release
// ============================================================================
package di_pkg;

    localparam int DI_MODE_FIXED = 0;
    localparam int DI_MODE_RR    = 1;

    // Output register occupancy; the FULL encoding doubles as D_valid.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } di_state_e;

    // Smallest r with 2**r >= value (minimum 1 so index ports never collapse).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/di_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : di_rr_arbiter
//  Purpose  : Combinational arbiter. Picks the first eligible channel at or
//             after a start index, wrapping modulo NCH. With mode=0 the start
//             index is 0, giving fixed priority (channel 0 highest).
//  Ports    : eligible  - per-channel eligibility
//             rr_ptr    - round-robin start index
//             mode      - 1 = start at rr_ptr, 0 = start at channel 0
//             grant     - one-hot winner (zero if nothing eligible)
//             grant_id  - index of winner
//             any_grant - at least one channel eligible
//  Revision : 1.0 - initial release
// ============================================================================
module di_rr_arbiter
    import di_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IDW = clog2(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [IDW-1:0] rr_ptr,
    input  logic           mode,
    output logic [NCH-1:0] grant,
    output logic [IDW-1:0] grant_id,
    output logic           any_grant
);

    logic [IDW-1:0] w_base;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_chan;

    // Scan channels in order starting at w_base; the first eligible one wins.
    // The extra bit on w_sum lets base+offset exceed NCH before wrapping.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        w_base    = mode ? rr_ptr : '0;
        w_sum     = '0;
        w_chan    = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = {1'b0, w_base} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NCH)) begin
                w_sum = w_sum - (IDW+1)'(NCH);
            end
            w_chan = w_sum[IDW-1:0];
            if (!any_grant && eligible[w_chan]) begin
                grant[w_chan] = 1'b1;
                grant_id      = w_chan;
                any_grant     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/di_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : di_sel_arbiter
//  Purpose  : Registered data-input selector. Arbitrates NCH request/data
//             sources into a one-word output register held under a
//             valid/ready handshake, with a forced-select override.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             req, data_in      - per-channel request and flattened data
//             force_en,force_sel- restrict eligibility to one channel
//             gnt               - one-hot, channel captured at coming edge
//             D, D_valid        - output word and occupancy
//             D_ready           - consumer accepts D at this edge
//             gnt_id            - index of channel whose word is in D
//  Revision : 1.0 - initial release
// ============================================================================
module di_sel_arbiter
    import di_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = DI_MODE_FIXED,
    parameter int IDW   = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic                 force_en,
    input  logic [IDW-1:0]       force_sel,
    output logic [NCH-1:0]       gnt,
    output logic [WIDTH-1:0]     D,
    output logic                 D_valid,
    input  logic                 D_ready,
    output logic [IDW-1:0]       gnt_id
);

    di_state_e      r_state;
    di_state_e      w_state_next;
    logic [WIDTH-1:0] r_d;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_rr_ptr;

    logic [NCH-1:0] w_force_mask;
    logic [NCH-1:0] w_eligible;
    logic           w_rr_mode;
    logic [NCH-1:0] w_grant;
    logic [IDW-1:0] w_win_id;
    logic           w_any;
    logic           w_load;

    // A force_sel at or beyond NCH shifts the single bit out, leaving no
    // channel eligible.
    assign w_force_mask = {{(NCH-1){1'b0}}, 1'b1} << force_sel;
    assign w_eligible   = force_en ? (req & w_force_mask) : req;
    assign w_rr_mode    = (MODE == DI_MODE_RR) && !force_en;

    di_rr_arbiter #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_arb (
        .eligible  (w_eligible),
        .rr_ptr    (r_rr_ptr),
        .mode      (w_rr_mode),
        .grant     (w_grant),
        .grant_id  (w_win_id),
        .any_grant (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = w_any && ((r_state == ST_EMPTY) || D_ready) && !reset;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end else if (D_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_d      <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_d      <= data_in[w_win_id*WIDTH +: WIDTH];
                r_gnt_id <= w_win_id;
            end
            // Pointer advances only on unforced round-robin loads.
            if (w_load && w_rr_mode) begin
                r_rr_ptr <= (w_win_id == IDW'(NCH-1)) ? '0 : w_win_id + 1'b1;
            end
        end
    end

    assign gnt     = w_load ? w_grant : '0;
    assign D       = r_d;
    assign D_valid = (r_state == ST_FULL);
    assign gnt_id  = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_di_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_di_sel_arbiter
//  Purpose  : Directed-vector bench for di_sel_arbiter. Three instances:
//             fixed priority NCH=4, round-robin NCH=4, fixed priority NCH=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_di_sel_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] data_in;
    logic         force_en;
    logic [1:0]   force_sel;
    logic         D_ready;

    logic [2:0]   req3;
    logic [95:0]  data3;
    logic         force_en3;
    logic [1:0]   force_sel3;
    logic         D_ready3;

    logic [3:0]   gnt_fix,  gnt_rr;
    logic [31:0]  d_fix,    d_rr;
    logic         v_fix,    v_rr;
    logic [1:0]   id_fix,   id_rr;
    logic [2:0]   gnt3;
    logic [31:0]  d3;
    logic         v3;
    logic [1:0]   id3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    di_sel_arbiter #(.WIDTH(32), .NCH(4), .MODE(0)) u_fix (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .force_en(force_en), .force_sel(force_sel), .gnt(gnt_fix),
        .D(d_fix), .D_valid(v_fix), .D_ready(D_ready), .gnt_id(id_fix)
    );

    di_sel_arbiter #(.WIDTH(32), .NCH(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .force_en(force_en), .force_sel(force_sel), .gnt(gnt_rr),
        .D(d_rr), .D_valid(v_rr), .D_ready(D_ready), .gnt_id(id_rr)
    );

    di_sel_arbiter #(.WIDTH(32), .NCH(3), .MODE(0)) u_n3 (
        .clk(clk), .reset(reset), .req(req3), .data_in(data3),
        .force_en(force_en3), .force_sel(force_sel3), .gnt(gnt3),
        .D(d3), .D_valid(v3), .D_ready(D_ready3), .gnt_id(id3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        #1;
        if (gnt_fix !== 4'b0000) begin
            $display("FAIL reset_gnt: got %b expected %b", gnt_fix, 4'b0000); n_err++;
        end
        n_vec++;
        if (d_fix !== 32'h0) begin
            $display("FAIL reset_D: got %h expected %h", d_fix, 32'h0); n_err++;
        end
        n_vec++;
        if (v_fix !== 1'b0) begin
            $display("FAIL reset_valid: got %b expected %b", v_fix, 1'b0); n_err++;
        end
        n_vec++;
        if (id_fix !== 2'd0) begin
            $display("FAIL reset_gnt_id: got %0d expected %0d", id_fix, 0); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_basic_load();
        tick();
        reset   = 1'b0;
        req     = 4'b0010;
        data_in[32 +: 32] = 32'hDEADBEEF;
        D_ready = 1'b1;
        #1;
        if (gnt_fix !== 4'b0010) begin
            $display("FAIL load_gnt: got %b expected %b", gnt_fix, 4'b0010); n_err++;
        end
        n_vec++;
        tick();
        req = 4'b0000;
        if (d_fix !== 32'hDEADBEEF) begin
            $display("FAIL load_D: got %h expected %h", d_fix, 32'hDEADBEEF); n_err++;
        end
        n_vec++;
        if (v_fix !== 1'b1) begin
            $display("FAIL load_valid: got %b expected %b", v_fix, 1'b1); n_err++;
        end
        n_vec++;
        if (id_fix !== 2'd1) begin
            $display("FAIL load_gnt_id: got %0d expected %0d", id_fix, 1); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_fixed_priority();
        req     = 4'b1110;
        D_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in[32 +: 32] = 32'h1100_0000 + i;
            #1;
            if (gnt_fix !== 4'b0010) begin
                $display("FAIL fixed_gnt[%0d]: got %b expected %b", i, gnt_fix, 4'b0010); n_err++;
            end
            n_vec++;
            tick();
            if (id_fix !== 2'd1 || d_fix !== 32'h1100_0000 + i) begin
                $display("FAIL fixed_capture[%0d]: got id %0d D %h expected id 1 D %h",
                         i, id_fix, d_fix, 32'h1100_0000 + i); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        req     = 4'b1111;
        D_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            data_in[c*32 +: 32] = 32'hA000_0000 + c;
        end
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << (i % 4);
            #1;
            if (gnt_rr !== exp_gnt) begin
                $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_rr, exp_gnt); n_err++;
            end
            n_vec++;
            tick();
            if (id_rr !== 2'(i % 4) || d_rr !== 32'hA000_0000 + (i % 4)) begin
                $display("FAIL rr_seq[%0d]: got id %0d D %h expected id %0d D %h",
                         i, id_rr, d_rr, i % 4, 32'hA000_0000 + (i % 4)); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_backpressure();
        // u_fix holds channel 0's word from the round-robin phase.
        D_ready = 1'b0;
        req     = 4'b0100;
        data_in[64 +: 32] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (gnt_fix !== 4'b0000) begin
                $display("FAIL stall_gnt[%0d]: got %b expected %b", i, gnt_fix, 4'b0000); n_err++;
            end
            n_vec++;
            tick();
            if (d_fix !== 32'hA000_0000 || id_fix !== 2'd0 || v_fix !== 1'b1) begin
                $display("FAIL stall_hold[%0d]: got D %h id %0d v %b expected D a0000000 id 0 v 1",
                         i, d_fix, id_fix, v_fix); n_err++;
            end
            n_vec++;
        end
        D_ready = 1'b1;
        #1;
        if (gnt_fix !== 4'b0100) begin
            $display("FAIL release_gnt: got %b expected %b", gnt_fix, 4'b0100); n_err++;
        end
        n_vec++;
        tick();
        if (d_fix !== 32'hC2C2C2C2 || id_fix !== 2'd2 || v_fix !== 1'b1) begin
            $display("FAIL release_capture: got D %h id %0d v %b expected D c2c2c2c2 id 2 v 1",
                     d_fix, id_fix, v_fix); n_err++;
        end
        n_vec++;
        req = 4'b0000;
        tick();
        if (v_fix !== 1'b0 || d_fix !== 32'hC2C2C2C2 || id_fix !== 2'd2) begin
            $display("FAIL drain: got v %b D %h id %0d expected v 0 D c2c2c2c2 id 2",
                     v_fix, d_fix, id_fix); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_force();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        D_ready = 1'b1;
        req     = 4'b0010;
        data_in[32 +: 32] = 32'hB1B1B1B1;
        tick();
        if (id_rr !== 2'd1) begin
            $display("FAIL force_pre_id: got %0d expected %0d", id_rr, 1); n_err++;
        end
        n_vec++;
        // rr_ptr is now 2
        force_en  = 1'b1;
        force_sel = 2'd3;
        req       = 4'b1001;
        data_in[96 +: 32] = 32'hF3F3F3F3;
        #1;
        if (gnt_rr !== 4'b1000 || gnt_fix !== 4'b1000) begin
            $display("FAIL force_gnt: got rr %b fix %b expected 1000", gnt_rr, gnt_fix); n_err++;
        end
        n_vec++;
        tick();
        if (d_rr !== 32'hF3F3F3F3 || id_rr !== 2'd3) begin
            $display("FAIL force_capture: got D %h id %0d expected D f3f3f3f3 id 3", d_rr, id_rr); n_err++;
        end
        n_vec++;
        force_sel = 2'd1;
        #1;
        if (gnt_rr !== 4'b0000) begin
            $display("FAIL force_noreq_gnt: got %b expected %b", gnt_rr, 4'b0000); n_err++;
        end
        n_vec++;
        tick();
        if (v_rr !== 1'b0) begin
            $display("FAIL force_noreq_valid: got %b expected %b", v_rr, 1'b0); n_err++;
        end
        n_vec++;
        force_en = 1'b0;
        req      = 4'b1111;
        #1;
        if (gnt_rr !== 4'b0100) begin
            $display("FAIL force_ptr_kept: got %b expected %b", gnt_rr, 4'b0100); n_err++;
        end
        n_vec++;
        tick();
        if (id_rr !== 2'd2) begin
            $display("FAIL force_ptr_id: got %0d expected %0d", id_rr, 2); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_nch3_force();
        D_ready3   = 1'b1;
        force_en3  = 1'b1;
        force_sel3 = 2'd3;
        req3       = 3'b111;
        data3      = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        #1;
        if (gnt3 !== 3'b000) begin
            $display("FAIL n3_oob_gnt: got %b expected %b", gnt3, 3'b000); n_err++;
        end
        n_vec++;
        tick();
        if (v3 !== 1'b0) begin
            $display("FAIL n3_oob_valid: got %b expected %b", v3, 1'b0); n_err++;
        end
        n_vec++;
        force_sel3 = 2'd2;
        #1;
        if (gnt3 !== 3'b100) begin
            $display("FAIL n3_sel2_gnt: got %b expected %b", gnt3, 3'b100); n_err++;
        end
        n_vec++;
        tick();
        if (d3 !== 32'h3333_0002 || id3 !== 2'd2 || v3 !== 1'b1) begin
            $display("FAIL n3_sel2_capture: got D %h id %0d v %b expected D 33330002 id 2 v 1",
                     d3, id3, v3); n_err++;
        end
        n_vec++;
        req3 = 3'b000;
    endtask

    task automatic test_reset_full();
        force_en = 1'b0;
        req      = 4'b1111;
        D_ready  = 1'b1;
        tick();
        if (v_fix !== 1'b1 || d_fix !== 32'hA000_0000) begin
            $display("FAIL rstfull_pre: got v %b D %h expected v 1 D a0000000", v_fix, d_fix); n_err++;
        end
        n_vec++;
        reset = 1'b1;
        #1;
        if (gnt_fix !== 4'b0000 || gnt_rr !== 4'b0000) begin
            $display("FAIL rstfull_gnt: got fix %b rr %b expected 0000", gnt_fix, gnt_rr); n_err++;
        end
        n_vec++;
        tick();
        if (v_fix !== 1'b0 || d_fix !== 32'h0 || id_fix !== 2'd0) begin
            $display("FAIL rstfull_clear: got v %b D %h id %0d expected v 0 D 0 id 0",
                     v_fix, d_fix, id_fix); n_err++;
        end
        n_vec++;
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        if (gnt_rr !== 4'b0001) begin
            $display("FAIL rstfull_ptr: got %b expected %b", gnt_rr, 4'b0001); n_err++;
        end
        n_vec++;
        req = 4'b0000;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        data_in    = '0;
        force_en   = 1'b0;
        force_sel  = '0;
        D_ready    = 1'b0;
        req3       = '0;
        data3      = '0;
        force_en3  = 1'b0;
        force_sel3 = '0;
        D_ready3   = 1'b0;

        test_reset();
        test_basic_load();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_force();
        test_nch3_force();
        test_reset_full();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
